// File: rtl/udp_pkg.sv
// Shared UDP header layout and receive FSM encoding for udp_rx_wide.
package udp_pkg;
    localparam int HDR_LEN  = 8;
    localparam int PORT_W   = 16;
    localparam int OFF_SRC  = 0;
    localparam int OFF_DST  = 2;
    localparam int OFF_LEN  = 4;
    localparam int OFF_CSUM = 6;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        HEAD = 4'b0010,
        DATA = 4'b0100,
        SKIP = 4'b1000
    } state_e;

    // Fields are big-endian on the wire and wire byte 0 sits in the low bits.
    function automatic logic [PORT_W-1:0] hdr_field(input logic [63:0] hdr, input int off);
        return {hdr[off*8 +: 8], hdr[off*8+8 +: 8]};
    endfunction
endpackage

// File: rtl/udp_csum.sv
// One's-complement accumulator over DATA_W-wide beats with end-around fold.
// Only instantiated by udp_rx_wide when UDP_CHECKSUM_EN is defined.
module udp_csum #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = $clog2(DATA_W/8)+1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [15:0]       init_i,
    output logic [15:0]       sum_o
);
    localparam int WORDS = DATA_W/16;

    logic [31:0] acc_q, acc_d, beat_sum, fold1;

    always_comb begin
        beat_sum = '0;
        // Bytes past len_i count as zero, which also pads an odd final byte.
        for (int w = 0; w < WORDS; w++) begin
            beat_sum = beat_sum + {16'd0,
                ((2*w)   < int'(len_i)) ? data_i[16*w +: 8]   : 8'd0,
                ((2*w+1) < int'(len_i)) ? data_i[16*w+8 +: 8] : 8'd0};
        end
        acc_d = acc_q;
        if (en_i) acc_d = (first_i ? {16'd0, init_i} : acc_q) + beat_sum;
        fold1 = {16'd0, acc_q[31:16]} + {16'd0, acc_q[15:0]};
        sum_o = fold1[15:0] + {15'd0, fold1[16]};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) acc_q <= '0;
        else         acc_q <= acc_d;
    end
endmodule

// File: rtl/udp_rx_wide.sv
// UDP receive: strips the 8-byte header, filters on ports, trims IP padding.
// Define UDP_CHECKSUM_EN to verify the UDP checksum (output latency becomes 2).
module udp_rx_wide
    import udp_pkg::*;
#(
    parameter int                   DATA_W    = 64,
    parameter int                   LEN_W     = $clog2(DATA_W/8)+1,
    parameter int                   N_PORT    = 4,
    parameter logic [N_PORT*16-1:0] DST_PORTS = {16'd18070, 16'd18071, 16'd18072, 16'd18073},
    parameter logic [15:0]          SRC_PORT  = 16'd18070
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic [LEN_W-1:0]          len_i,
    input  logic                      last_i,
    input  logic                      cancel_i,
    input  logic                      ip_cs_err_i,
    input  logic [15:0]               ip_ph_sum_i,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [LEN_W-1:0]          len_o,
    output logic                      last_o,
    output logic [$clog2(N_PORT)-1:0] port_idx_o,
    output logic                      cancel_o
);
    localparam int BPB    = DATA_W/8;
    localparam int PIDX_W = $clog2(N_PORT);

    if (DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("udp_rx_wide: DATA_W must be 16, 32 or 64");
    end

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d, ulen_q, ulen_d;
    logic [63:0]         hdr_q, hdr_d, hdr_w;
    logic [PIDX_W-1:0]   pidx_q, pidx_d, hit_idx;
    logic                vo_q, vo_d, last_q, last_d, canc_q, canc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [5:0]          hoff;
    logic [15:0]         src_f, dst_f, len_f;
    logic [16:0]         cnt_sum;
    logic                dst_hit, hdr_beat, hdr_end, hdr_bad;

    always_comb begin
        // Header beats are always full, so the byte count gives the bit offset.
        hoff = {cnt_q[2:0], 3'b000};
        hdr_w = hdr_q;
        hdr_w[hoff +: DATA_W] = data_i;
        src_f = hdr_field(hdr_w, OFF_SRC);
        dst_f = hdr_field(hdr_w, OFF_DST);
        len_f = hdr_field(hdr_w, OFF_LEN);
        dst_hit = 1'b0;
        hit_idx = '0;
        for (int i = N_PORT-1; i >= 0; i--) begin
            if (dst_f == DST_PORTS[(N_PORT-1-i)*16 +: 16]) begin
                dst_hit = 1'b1;
                hit_idx = PIDX_W'(i);
            end
        end
        cnt_sum  = {1'b0, cnt_q} + 17'(len_i);
        hdr_beat = valid_i && ((state_q == IDLE) || (state_q == HEAD));
        hdr_end  = (cnt_q == 16'(HDR_LEN - BPB));
        hdr_bad  = (len_i != LEN_W'(BPB)) || ip_cs_err_i ||
                   (hdr_end && (((SRC_PORT != 16'd0) && (src_f != SRC_PORT)) ||
                                !dst_hit || (len_f < 16'(HDR_LEN))));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = valid_i ? cnt_sum[15:0] : cnt_q;
        hdr_d   = hdr_q;
        ulen_d  = ulen_q;
        pidx_d  = pidx_q;
        vo_d    = 1'b0;
        last_d  = 1'b0;
        canc_d  = 1'b0;
        data_d  = data_q;
        len_d   = len_q;
        case (state_q)
            IDLE, HEAD: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else if (hdr_beat) begin
                    hdr_d = hdr_w;
                    if (hdr_bad) begin
                        state_d = last_i ? IDLE : SKIP;
                    end else if (hdr_end) begin
                        ulen_d  = len_f;
                        pidx_d  = hit_idx;
                        state_d = last_i ? IDLE : ((len_f == 16'(HDR_LEN)) ? SKIP : DATA);
                    end else begin
                        state_d = last_i ? IDLE : HEAD;
                    end
                end
            end
            DATA: begin
                if (cancel_i || (valid_i && ip_cs_err_i)) begin
                    canc_d  = 1'b1;
                    state_d = IDLE;
                end else if (valid_i) begin
                    if (cnt_sum >= {1'b0, ulen_q}) begin
                        vo_d    = 1'b1;
                        last_d  = 1'b1;
                        data_d  = data_i;
                        len_d   = LEN_W'(ulen_q - cnt_q);
                        state_d = last_i ? IDLE : SKIP;
                    end else if (last_i) begin
                        // Truncated packet: the application must drop what it got.
                        canc_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        vo_d   = 1'b1;
                        data_d = data_i;
                        len_d  = len_i;
                    end
                end
            end
            SKIP: begin
                if (cancel_i || (valid_i && last_i)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            ulen_q  <= '0;
            pidx_q  <= '0;
            vo_q    <= 1'b0;
            last_q  <= 1'b0;
            canc_q  <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            ulen_q  <= ulen_d;
            pidx_q  <= pidx_d;
            vo_q    <= vo_d;
            last_q  <= last_d;
            canc_q  <= canc_d;
            data_q  <= data_d;
            len_q   <= len_d;
        end
    end

`ifdef UDP_CHECKSUM_EN
    logic [15:0]       rxcs_q, rxcs_d, csum_sum;
    logic              csum_en, csum_bad;
    logic              v2_q, v2_d, last2_q, last2_d, canc2_q, canc2_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [LEN_W-1:0]  len2_q, len2_d;
    logic [PIDX_W-1:0] pidx2_q, pidx2_d;

    udp_csum #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_csum (
        .clk     (clk),
        .nreset  (nreset),
        .en_i    (csum_en),
        .first_i (state_q == IDLE),
        .data_i  (data_i),
        .len_i   ((state_q == DATA) ? len_d : len_i),
        .init_i  (ip_ph_sum_i),
        .sum_o   (csum_sum)
    );

    always_comb begin
        rxcs_d = rxcs_q;
        if (hdr_beat && !cancel_i && hdr_end && !hdr_bad) rxcs_d = hdr_field(hdr_w, OFF_CSUM);
        csum_en  = (hdr_beat && !cancel_i) || vo_d;
        // The accumulator already holds the final beat when stage one shows last.
        csum_bad = last_q && (rxcs_q != 16'd0) && (csum_sum != 16'hFFFF);
        v2_d     = vo_q;
        last2_d  = last_q;
        canc2_d  = canc_q || csum_bad;
        data2_d  = vo_q ? data_q : data2_q;
        len2_d   = vo_q ? len_q : len2_q;
        pidx2_d  = pidx_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rxcs_q  <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            canc2_q <= 1'b0;
            data2_q <= '0;
            len2_q  <= '0;
            pidx2_q <= '0;
        end else begin
            rxcs_q  <= rxcs_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            canc2_q <= canc2_d;
            data2_q <= data2_d;
            len2_q  <= len2_d;
            pidx2_q <= pidx2_d;
        end
    end

    assign valid_o    = v2_q;
    assign data_o     = data2_q;
    assign len_o      = len2_q;
    assign last_o     = last2_q;
    assign cancel_o   = canc2_q;
    assign port_idx_o = pidx2_q;
`else
    logic unused_csum;
    assign unused_csum = ^ip_ph_sum_i;

    assign valid_o    = vo_q;
    assign data_o     = data_q;
    assign len_o      = len_q;
    assign last_o     = last_q;
    assign cancel_o   = canc_q;
    assign port_idx_o = pidx_q;
`endif
endmodule
